reg_dump_reader: RTL and testbench

- Read-side master for the 32x32 register file: on a start pulse it walks the read address from x0 to x31 and samples each register.
- It streams each (index, value) pair out over a valid/ready handshake.
- Sits beside the register file on a read port (drives ra, consumes DoutA) for debug dumps and bench state checks; never writes the register file.

---
 rtl/reg_dump_pkg.sv | 20 ++
 rtl/reg_dump_reader.sv | 120 ++++++++++++
 tb/tb_reg_dump_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared constants for the register-file dump reader: FSM encoding and default geometry.
package reg_dump_pkg;

  localparam int RD_NREGS = 32;
  localparam int RD_AW    = 5;
  localparam int RD_DW    = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_READ = S_READ,
    ST_SEND = S_SEND,
    ST_DONE = S_DONE
  } rd_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a register file read port from x0 to x(NREGS-1), streaming (index, value) beats.
// Define REG_DUMP_SKIP_ZERO_EN to drop zero-valued registers from the stream.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NREGS = RD_NREGS,
  parameter int AW    = RD_AW,
  parameter int DW    = RD_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   beats
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW:0]   BEAT_ONE = (AW+1)'(1);

  rd_state_e       state_q, state_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q,  data_d;
  logic [AW-1:0]   idx_q,   idx_d;
  logic            busy_q,  busy_d;
  logic [AW:0]     beats_q, beats_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    beats_d = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          addr_d  = '0;
          beats_d = '0;
          busy_d  = 1'b1;
        end
      end
      ST_READ: begin
`ifdef REG_DUMP_SKIP_ZERO_EN
        // Zero registers cost one READ cycle and produce no beat.
        if (rf_data == '0) begin
          if (addr_q == LAST_IDX) state_d = ST_DONE;
          else                    addr_d  = addr_q + AW'(1);
        end else begin
          data_d  = rf_data;
          idx_d   = addr_q;
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
`else
        data_d  = rf_data;
        idx_d   = addr_q;
        valid_d = 1'b1;
        state_d = ST_SEND;
`endif
      end
      ST_SEND: begin
        // Address only advances after the handshake, so it never passes LAST_IDX.
        if (valid_q && out_ready) begin
          beats_d = beats_q + BEAT_ONE;
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf_addr   = addr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign busy      = busy_q;
  assign done      = (state_q == ST_DONE);
  assign beats     = beats_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader with a behavioural register file and beat model.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  localparam int N  = RD_NREGS;
  localparam int AW = RD_AW;
  localparam int DW = RD_DW;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [AW-1:0] rf_addr, out_idx;
  logic [DW-1:0] rf_data, out_data;
  logic          out_valid, busy, done;
  logic [AW:0]   beats;

  always #5 clk = ~clk;

  logic [DW-1:0] rf   [N];
  logic [DW-1:0] snap [N];
  assign rf_data = (rf_addr == '0) ? '0 : rf[rf_addr];

  reg_dump_reader dut (
    .clk(clk), .reset(reset), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done), .beats(beats)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] cap_idx[$], exp_idx[$];
  logic [DW-1:0] cap_data[$], exp_data[$];
  int done_cnt, done_cyc, stall_bad, busy_late, busy1;
  bit timeout;

  // Expected stream: every register in order, x0 reads as zero; zero values dropped when skipping.
  task automatic build_exp();
    logic [DW-1:0] v;
    exp_idx.delete(); exp_data.delete();
    for (int i = 0; i < N; i++) begin
      v = (i == 0) ? '0 : snap[i];
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (v != '0) begin exp_idx.push_back(AW'(i)); exp_data.push_back(v); end
`else
      exp_idx.push_back(AW'(i)); exp_data.push_back(v);
`endif
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < N; i++) snap[i] = rf[i];
  endtask

  // Drives one dump and records what the sink saw; comparisons live in the test tasks.
  task automatic do_dump(input int rmode, input bit sbusy, input bit cwr);
    logic [AW-1:0] pidx;
    logic [DW-1:0] pdata;
    bit pstall, p5, p31, w3, w5;
    int c;
    cap_idx.delete(); cap_data.delete();
    done_cnt = 0; done_cyc = -1; stall_bad = 0; busy_late = 0; busy1 = 0; timeout = 0;
    pstall = 0; p5 = 0; p31 = 0; w3 = 0; w5 = 0; pidx = '0; pdata = '0;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (c == 1) busy1 = busy;
      if (pstall && (!out_valid || out_idx !== pidx || out_data !== pdata)) stall_bad++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin cap_idx.push_back(out_idx); cap_data.push_back(out_data); end
      pstall = out_valid && !out_ready; pidx = out_idx; pdata = out_data;
      if (sbusy && cap_idx.size() == 5  && !p5)  begin start = 1'b1; p5  = 1; end
      if (sbusy && cap_idx.size() == 31 && !p31) begin start = 1'b1; p31 = 1; end
      if (cwr && out_valid && out_idx == 3 && !w3) begin rf[7] = 32'hDEADBEEF; w3 = 1; end
      if (cwr && out_valid && out_idx == 5 && !w5) begin rf[2] = 32'h1; w5 = 1; end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; if (sbusy) start = 1'b1; end
      end
      if (done_cyc >= 0 && c > done_cyc && (busy || out_valid)) busy_late++;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
      if (c >= 4000) begin timeout = 1; break; end
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (rf_addr !== '0)  begin n_fail++; $display("FAIL reset_rf_addr got %0h want 0", rf_addr); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    n_tests++; if (out_idx !== '0)  begin n_fail++; $display("FAIL reset_out_idx got %0h want 0", out_idx); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_tests++; if (beats !== '0)    begin n_fail++; $display("FAIL reset_beats got %0h want 0", beats); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < N; i++) rf[i] = 32'hA5000000 + i;
    take_snap(); build_exp();
    do_dump(0, 0, 0);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL full_timeout no done within bound"); end
    n_tests++; if (cap_idx.size() != exp_idx.size()) begin n_fail++; $display("FAIL full_count got %0d want %0d", cap_idx.size(), exp_idx.size()); end
    for (int i = 0; i < cap_idx.size() && i < exp_idx.size(); i++) begin
      n_tests++;
      if (cap_idx[i] !== exp_idx[i] || cap_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL full_beat%0d got %0d:%h want %0d:%h", i, cap_idx[i], cap_data[i], exp_idx[i], exp_data[i]);
      end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_cnt got %0d want 1", done_cnt); end
    // Start cycle plus done cycle, one READ per register and one SEND per beat.
    n_tests++; if (done_cyc + 1 != N + exp_idx.size() + 2) begin n_fail++; $display("FAIL full_latency got %0d want %0d", done_cyc + 1, N + exp_idx.size() + 2); end
    n_tests++; if (beats !== (AW+1)'(exp_idx.size())) begin n_fail++; $display("FAIL full_beats got %0d want %0d", beats, exp_idx.size()); end
    n_tests++; if (busy1 !== 1) begin n_fail++; $display("FAIL full_busy got %0d want 1", busy1); end
    n_tests++; if (busy_late != 0) begin n_fail++; $display("FAIL full_idle_after got %0d want 0", busy_late); end
  endtask

  task automatic test_backpressure(input int rmode);
    for (int i = 0; i < N; i++) rf[i] = $urandom;
    take_snap(); build_exp();
    do_dump(rmode, 0, 0);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL bp%0d_timeout no done within bound", rmode); end
    n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp%0d_stall_stable got %0d changes want 0", rmode, stall_bad); end
    n_tests++; if (cap_idx.size() != exp_idx.size()) begin n_fail++; $display("FAIL bp%0d_count got %0d want %0d", rmode, cap_idx.size(), exp_idx.size()); end
    for (int i = 0; i < cap_idx.size() && i < exp_idx.size(); i++) begin
      n_tests++;
      if (cap_idx[i] !== exp_idx[i] || cap_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL bp%0d_beat%0d got %0d:%h want %0d:%h", rmode, i, cap_idx[i], cap_data[i], exp_idx[i], exp_data[i]);
      end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp%0d_done_cnt got %0d want 1", rmode, done_cnt); end
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < N; i++) rf[i] = 32'h5A000000 | i;
    take_snap(); build_exp();
    do_dump(0, 1, 0);
    n_tests++; if (cap_idx.size() != exp_idx.size()) begin n_fail++; $display("FAIL busy_count got %0d want %0d", cap_idx.size(), exp_idx.size()); end
    for (int i = 0; i < cap_idx.size() && i < exp_idx.size(); i++) begin
      n_tests++;
      if (cap_idx[i] !== exp_idx[i]) begin n_fail++; $display("FAIL busy_idx%0d got %0d want %0d", i, cap_idx[i], exp_idx[i]); end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done_cnt got %0d want 1", done_cnt); end
    n_tests++; if (busy_late != 0) begin n_fail++; $display("FAIL busy_start_at_done got %0d restarts want 0", busy_late); end
  endtask

  task automatic test_reset_mid();
    int c;
    bit seen;
    for (int i = 0; i < N; i++) rf[i] = 32'hC0000000 + i;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 10) seen = 1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rmid_reach_idx10 not reached"); end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({rf_addr, out_valid, out_data, out_idx, busy, done, beats} !== '0) begin
      n_fail++; $display("FAIL rmid_async_clear got addr=%0d v=%0b d=%h i=%0d b=%0b dn=%0b bt=%0d want all 0",
                         rf_addr, out_valid, out_data, out_idx, busy, done, beats);
    end
    seen = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (done) seen = 1; end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (done) seen = 1; end
    n_tests++; if (seen) begin n_fail++; $display("FAIL rmid_no_done got done=1 want 0"); end
    take_snap(); build_exp();
    do_dump(0, 0, 0);
    n_tests++; if (cap_idx.size() != exp_idx.size() || cap_idx.size() == 0 || cap_idx[0] !== exp_idx[0]) begin
      n_fail++; $display("FAIL rmid_restart got %0d beats want %0d from idx %0d", cap_idx.size(), exp_idx.size(), exp_idx[0]);
    end
  endtask

  task automatic test_concurrent_write();
    for (int i = 0; i < N; i++) rf[i] = 32'h10000000 + 32'(i) * 32'h11;
    take_snap();
    snap[7] = 32'hDEADBEEF;   // lands before x7 is read; x2's later write must not show
    build_exp();
    do_dump(0, 0, 1);
    n_tests++; if (cap_idx.size() != exp_idx.size()) begin n_fail++; $display("FAIL cw_count got %0d want %0d", cap_idx.size(), exp_idx.size()); end
    for (int i = 0; i < cap_idx.size() && i < exp_idx.size(); i++) begin
      n_tests++;
      if (cap_idx[i] !== exp_idx[i] || cap_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL cw_beat%0d got %0d:%h want %0d:%h", i, cap_idx[i], cap_data[i], exp_idx[i], exp_data[i]);
      end
    end
  endtask

`ifdef REG_DUMP_SKIP_ZERO_EN
  task automatic test_skip_zero();
    for (int i = 0; i < N; i++) rf[i] = '0;
    rf[4] = 32'h44; rf[31] = 32'h1F;
    do_dump(0, 0, 0);
    n_tests++; if (cap_idx.size() != 2 || cap_idx[0] !== AW'(4) || cap_idx[1] !== AW'(31) || cap_data[0] !== 32'h44 || cap_data[1] !== 32'h1F) begin
      n_fail++; $display("FAIL skip_sparse got %0d beats want 2 (4:44, 31:1F)", cap_idx.size());
    end
    n_tests++; if (beats !== (AW+1)'(2)) begin n_fail++; $display("FAIL skip_beats got %0d want 2", beats); end
    n_tests++; if (done_cyc + 1 != N + 2 + 2) begin n_fail++; $display("FAIL skip_latency got %0d want %0d", done_cyc + 1, N + 4); end
    for (int i = 0; i < N; i++) rf[i] = '0;
    do_dump(0, 0, 0);
    n_tests++; if (cap_idx.size() != 0) begin n_fail++; $display("FAIL skip_allzero_count got %0d want 0", cap_idx.size()); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL skip_allzero_done got %0d want 1", done_cnt); end
    n_tests++; if (beats !== '0) begin n_fail++; $display("FAIL skip_allzero_beats got %0d want 0", beats); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) rf[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure(1);
    test_backpressure(2);
    test_start_busy();
    test_reset_mid();
    test_concurrent_write();
`ifdef REG_DUMP_SKIP_ZERO_EN
    test_skip_zero();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
